// File: rtl/triangle_stream_decoder_if.sv
// Host/rasteriser bus of the triangle stream decoder.
//   master : host side (drives the word stream and the pop request)
//   slave  : decoder side (drives buffer status, flags and head triangle)
// Signals:
//   fifo_write, fifo_w_data          host word strobe and 32-bit packet word
//   next_triangle                    pop request for the head triangle
//   fifo_full, tri_count, data_ready buffer status
//   opcode_received, proto_error     one-cycle header pulses
//   frame_ready, overflow            sticky status levels
//   x1..y3, TexNum                   head triangle
interface triangle_stream_decoder_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TEX_W = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              fifo_write;
    logic [31:0]       fifo_w_data;
    logic              next_triangle;
    logic              fifo_full;
    logic [CNT_W-1:0]  tri_count;
    logic              opcode_received;
    logic              frame_ready;
    logic              data_ready;
    logic [15:0]       x1, y1, x2, y2, x3, y3;
    logic [TEX_W-1:0]  TexNum;
    logic              overflow;
    logic              proto_error;

    modport master (
        output fifo_write, fifo_w_data, next_triangle,
        input  fifo_full, tri_count, opcode_received, frame_ready, data_ready,
        input  x1, y1, x2, y2, x3, y3, TexNum, overflow, proto_error
    );

    modport slave (
        input  fifo_write, fifo_w_data, next_triangle,
        output fifo_full, tri_count, opcode_received, frame_ready, data_ready,
        output x1, y1, x2, y2, x3, y3, TexNum, overflow, proto_error
    );
endinterface

// File: rtl/triangle_stream_decoder.sv
// Triangle stream decoder: assembles 4-word packets (header, v1, v2, v3)
// from the host word stream, queues up to DEPTH triangles in a circular
// buffer and presents the head triangle to the rasteriser.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    triangle_stream_decoder_if.slave (word stream in, head triangle,
//          buffer status and protocol flags out)
module triangle_stream_decoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TEX_W = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    triangle_stream_decoder_if.slave         bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = TEX_W + 96;

    typedef enum logic [1:0] {HDR, V1, V2, V3} state_t;

    state_t              state;
    logic [TEX_W-1:0]    tex_q;
    logic [31:0]         v1_q, v2_q;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]    count, cnt_next;
    logic [ENTRY_W-1:0]  head_q, new_entry;
    logic                op_pulse_q, perr_pulse_q, frame_q, ovf_q;
    logic                is_full, pop, commit;

    always_comb begin
        is_full   = (count == CNT_W'(DEPTH));
        pop       = bus.next_triangle && (count != '0);
        // A pop on the same edge frees the slot the commit needs.
        commit    = bus.fifo_write && (state == V3) && (!is_full || pop);
        rd_next   = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        new_entry = {tex_q, v1_q, v2_q, bus.fifo_w_data};
        cnt_next  = count;
        case ({commit, pop})
            2'b10:   cnt_next = count + CNT_W'(1);
            2'b01:   cnt_next = count - CNT_W'(1);
            default: cnt_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= HDR;
            tex_q        <= '0;
            v1_q         <= '0;
            v2_q         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            head_q       <= '0;
            op_pulse_q   <= 1'b0;
            perr_pulse_q <= 1'b0;
            frame_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            op_pulse_q   <= 1'b0;
            perr_pulse_q <= 1'b0;
            if (bus.fifo_write) begin
                case (state)
                    HDR: begin
                        case (bus.fifo_w_data[31:28])
                            4'd0: ;
                            4'd1: begin
                                tex_q      <= bus.fifo_w_data[TEX_W-1:0];
                                op_pulse_q <= 1'b1;
                                frame_q    <= 1'b0;
                                state      <= V1;
                            end
                            4'd2: begin
                                op_pulse_q <= 1'b1;
                                frame_q    <= 1'b1;
                            end
                            default: perr_pulse_q <= 1'b1;
                        endcase
                    end
                    V1: begin
                        v1_q  <= bus.fifo_w_data;
                        state <= V2;
                    end
                    V2: begin
                        v2_q  <= bus.fifo_w_data;
                        state <= V3;
                    end
                    default: begin
                        if (!commit) ovf_q <= 1'b1;
                        state <= HDR;
                    end
                endcase
            end
            if (commit) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            // The new entry is not in mem yet when it becomes the head,
            // so it is bypassed straight into the head register.
            if (commit && (rd_next == wr_ptr))
                head_q <= new_entry;
            else if (cnt_next != '0)
                head_q <= mem[rd_next];
        end
    end

    assign bus.fifo_full       = is_full;
    assign bus.tri_count       = count;
    assign bus.data_ready      = (count != '0);
    assign bus.opcode_received = op_pulse_q;
    assign bus.proto_error     = perr_pulse_q;
    assign bus.frame_ready     = frame_q;
    assign bus.overflow        = ovf_q;
    assign {bus.TexNum, bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3} = head_q;
endmodule

// File: tb/tb_triangle_stream_decoder.sv
// Self-checking bench for triangle_stream_decoder: directed steps plus a
// randomized phase, every cycle compared against a queue-based model.
module tb_triangle_stream_decoder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TEX_W = 8;

    typedef struct packed {
        logic [TEX_W-1:0] tex;
        logic [15:0] x1, y1, x2, y2, x3, y3;
    } tri_t;

    logic tb_clk;
    logic tb_reset;
    int   checks   = 0;
    int   failures = 0;

    triangle_stream_decoder_if #(.DEPTH(DEPTH), .TEX_W(TEX_W)) bus ();

    triangle_stream_decoder #(.DEPTH(DEPTH), .TEX_W(TEX_W)) dut (
        .clk   (tb_clk),
        .reset (tb_reset),
        .bus   (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Reference model state
    tri_t             m_q[$];
    tri_t             m_head;
    int               m_phase;
    logic [TEX_W-1:0] m_tex;
    logic [31:0]      m_v1, m_v2;
    logic             m_frame, m_ovf, m_op, m_perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_head  = '0;
        m_phase = 0;
        m_tex   = '0;
        m_v1    = '0;
        m_v2    = '0;
        m_frame = 1'b0;
        m_ovf   = 1'b0;
        m_op    = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [31:0] d, input logic pop);
        tri_t t;
        logic do_commit;
        do_commit = 1'b0;
        t         = '0;
        m_op      = 1'b0;
        m_perr    = 1'b0;
        if (wr) begin
            if (m_phase == 0) begin
                if (d[31:28] == 4'd1) begin
                    m_tex = d[TEX_W-1:0]; m_op = 1'b1; m_frame = 1'b0; m_phase = 1;
                end else if (d[31:28] == 4'd2) begin
                    m_op = 1'b1; m_frame = 1'b1;
                end else if (d[31:28] != 4'd0) begin
                    m_perr = 1'b1;
                end
            end else if (m_phase == 1) begin
                m_v1 = d; m_phase = 2;
            end else if (m_phase == 2) begin
                m_v2 = d; m_phase = 3;
            end else begin
                t = {m_tex, m_v1, m_v2, d};
                do_commit = 1'b1;
                m_phase = 0;
            end
        end
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (do_commit) begin
            if (m_q.size() < DEPTH) m_q.push_back(t);
            else m_ovf = 1'b1;
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic check_all();
        chk("fifo_full",       32'(bus.fifo_full),       32'(m_q.size() == DEPTH));
        chk("tri_count",       32'(bus.tri_count),       32'(m_q.size()));
        chk("data_ready",      32'(bus.data_ready),      32'(m_q.size() != 0));
        chk("opcode_received", 32'(bus.opcode_received), 32'(m_op));
        chk("proto_error",     32'(bus.proto_error),     32'(m_perr));
        chk("frame_ready",     32'(bus.frame_ready),     32'(m_frame));
        chk("overflow",        32'(bus.overflow),        32'(m_ovf));
        chk("TexNum",          32'(bus.TexNum),          32'(m_head.tex));
        chk("x1", 32'(bus.x1), 32'(m_head.x1));
        chk("y1", 32'(bus.y1), 32'(m_head.y1));
        chk("x2", 32'(bus.x2), 32'(m_head.x2));
        chk("y2", 32'(bus.y2), 32'(m_head.y2));
        chk("x3", 32'(bus.x3), 32'(m_head.x3));
        chk("y3", 32'(bus.y3), 32'(m_head.y3));
    endtask

    // Called at a negedge: drive, step model at the edge, check at next negedge.
    task automatic cyc(input logic wr, input logic [31:0] d, input logic pop);
        bus.fifo_write    = wr;
        bus.fifo_w_data   = d;
        bus.next_triangle = pop;
        @(posedge tb_clk);
        model_step(wr, d, pop);
        @(negedge tb_clk);
        check_all();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0);
    endtask

    task automatic send_tri(input logic [TEX_W-1:0] tex,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [15:0] e, input logic [15:0] f,
                            input logic pop_last, input int unsigned gap);
        cyc(1'b1, {4'h1, 28'(tex)}, 1'b0); idle(gap);
        cyc(1'b1, {a, b}, 1'b0);            idle(gap);
        cyc(1'b1, {c, d}, 1'b0);            idle(gap);
        cyc(1'b1, {e, f}, pop_last);
    endtask

    task automatic send_rand_tri();
        send_tri(TEX_W'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, $urandom_range(0, 1));
    endtask

    // Called at a negedge: asynchronous reset pulse of two cycles.
    task automatic do_reset();
        tb_reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge tb_clk);
        @(negedge tb_clk);
        check_all();
        tb_reset = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int unsigned r;
        logic [3:0]  op;
        bus.fifo_write    = 1'b0;
        bus.fifo_w_data   = '0;
        bus.next_triangle = 1'b0;
        tb_reset          = 1'b0;
        model_reset();
        @(negedge tb_clk);
        do_reset();
        chk("rst_tri_count", 32'(bus.tri_count), 32'd0);
        chk("rst_x1",        32'(bus.x1),        32'd0);

        // First triangle and its latency
        cyc(1'b1, {4'h1, 28'd2}, 1'b0);
        chk("hdr_pulse", 32'(bus.opcode_received), 32'd1);
        cyc(1'b1, {16'd3, 16'd4}, 1'b0);
        chk("pulse_once", 32'(bus.opcode_received), 32'd0);
        cyc(1'b1, {16'd5, 16'd6}, 1'b0);
        chk("not_ready_early", 32'(bus.data_ready), 32'd0);
        cyc(1'b1, {16'd7, 16'd8}, 1'b0);
        chk("first_ready", 32'(bus.data_ready), 32'd1);
        chk("first_tex",   32'(bus.TexNum), 32'd2);
        chk("first_x1",    32'(bus.x1), 32'd3);
        chk("first_y3",    32'(bus.y3), 32'd8);
        chk("first_count", 32'(bus.tri_count), 32'd1);
        chk("first_frame", 32'(bus.frame_ready), 32'd0);

        // Pop to empty, outputs hold; pop while empty is ignored
        cyc(1'b0, 32'h0, 1'b1);
        chk("pop_ready", 32'(bus.data_ready), 32'd0);
        chk("pop_hold_x2", 32'(bus.x2), 32'd5);
        cyc(1'b0, 32'h0, 1'b1);
        chk("empty_pop_count", 32'(bus.tri_count), 32'd0);
        chk("empty_pop_y3", 32'(bus.y3), 32'd8);

        // Fill, overflow, drain in order
        for (int unsigned k = 0; k < 4; k++)
            send_tri(TEX_W'(k), 16'(k*10+1), 16'(k*10+2), 16'(k*10+3),
                     16'(k*10+4), 16'(k*10+5), 16'(k*10+6), 1'b0, 0);
        send_tri(8'd4, 16'd41, 16'd42, 16'd43, 16'd44, 16'd45, 16'd46, 1'b0, 0);
        chk("ovf_full",  32'(bus.fifo_full), 32'd1);
        chk("ovf_flag",  32'(bus.overflow),  32'd1);
        chk("ovf_count", 32'(bus.tri_count), 32'd4);
        for (int unsigned k = 0; k < 4; k++) begin
            chk("drain_x1", 32'(bus.x1), k*10+1);
            cyc(1'b0, 32'h0, 1'b1);
        end
        // Pointer wrap rounds
        for (int unsigned round = 0; round < 2; round++) begin
            for (int unsigned k = 0; k < 4; k++) send_rand_tri();
            for (int unsigned k = 0; k < 4; k++) cyc(1'b0, 32'h0, 1'b1);
        end

        // Commit with simultaneous pop while full
        @(negedge tb_clk);
        do_reset();
        for (int unsigned k = 0; k < 4; k++)
            send_tri(TEX_W'(k), 16'(k*10+1), 16'(k*10+2), 16'(k*10+3),
                     16'(k*10+4), 16'(k*10+5), 16'(k*10+6), 1'b0, 0);
        send_tri(8'd9, 16'd51, 16'd52, 16'd53, 16'd54, 16'd55, 16'd56, 1'b1, 0);
        chk("swap_ovf",   32'(bus.overflow),  32'd0);
        chk("swap_count", 32'(bus.tri_count), 32'd4);
        for (int unsigned k = 0; k < 3; k++) cyc(1'b0, 32'h0, 1'b1);
        chk("swap_last_x1",  32'(bus.x1), 32'd51);
        chk("swap_last_tex", 32'(bus.TexNum), 32'd9);
        cyc(1'b0, 32'h0, 1'b1);

        // Frame marker, illegal opcode, NOP, TRI clears frame
        cyc(1'b1, {4'h2, 28'h0}, 1'b0);
        chk("eof_frame", 32'(bus.frame_ready), 32'd1);
        chk("eof_pulse", 32'(bus.opcode_received), 32'd1);
        cyc(1'b1, {4'h7, 28'h123}, 1'b0);
        chk("perr_pulse", 32'(bus.proto_error), 32'd1);
        chk("perr_frame", 32'(bus.frame_ready), 32'd1);
        cyc(1'b1, {4'h0, 28'h5}, 1'b0);
        chk("nop_perr", 32'(bus.proto_error), 32'd0);
        chk("nop_pulse", 32'(bus.opcode_received), 32'd0);
        send_tri(8'd5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 1'b0, 2);
        chk("tri_clears_frame", 32'(bus.frame_ready), 32'd0);
        cyc(1'b0, 32'h0, 1'b1);

        // Randomized traffic with gaps, pops, and stray opcodes
        for (int unsigned i = 0; i < 400; i++) begin
            if (m_phase == 0) begin
                r = $urandom_range(0, 7);
                if (r == 0)      op = 4'd0;
                else if (r <= 4) op = 4'd1;
                else if (r == 5) op = 4'd2;
                else             op = 4'($urandom_range(3, 15));
                w = {op, 28'($urandom)};
            end else begin
                w = $urandom;
            end
            cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) == 0);
        end

        // Reset in the middle of a packet discards it
        @(negedge tb_clk);
        do_reset();
        cyc(1'b1, {4'h1, 28'd3}, 1'b0);
        cyc(1'b1, {16'd100, 16'd101}, 1'b0);
        idle(3);
        do_reset();
        send_tri(8'd6, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 1'b0, 0);
        chk("mid_rst_count", 32'(bus.tri_count), 32'd1);
        chk("mid_rst_tex",   32'(bus.TexNum), 32'd6);
        chk("mid_rst_x1",    32'(bus.x1), 32'd11);
        chk("mid_rst_y3",    32'(bus.y3), 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
